lsu_mem_initiator: RTL and testbench
====================================

Name: lsu_mem_initiator

Overview:
- Load/store unit for the sequential core: the initiator side of the data-memory interface.
- Takes the core's memread/memwrite, the ALU-computed address and the rs2 store data.
- Issues one request per operation to a multi-cycle data-memory responder using a valid/ready request channel and a valid-only response channel.
- Returns size-extracted, sign/zero-extended load data to the core; holds the core stalled while busy.

Parameters:
- XLEN, 64: address/data width; only 64 is supported.
- TIMEOUT_CYCLES, 255: response watchdog limit; used only with LSU_TIMEOUT_EN.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- memread  in  1  core load request; sampled in IDLE only.
- memwrite  in  1  core store request; sampled in IDLE only; wins if memread is also high.
- funct3  in  3  access size/signedness (RV64 load/store encoding).
- alu_result  in  64  byte address.
- rs2  in  64  store data, LSB-aligned.
- busy  out  1  high whenever state is not IDLE; core stall.
- done  out  1  one-cycle completion pulse.
- load_data  out  64  extended load result; valid from done, held until the next load completes.
- fault_misaligned  out  1  valid with done.
- fault_illegal  out  1  valid with done.
- fault_timeout  out  1  valid with done.
- mem_req_valid  out  1  request valid.
- mem_req_ready  in  1  responder accepts the request.
- mem_addr  out  64  doubleword-aligned address {addr[63:3],3'b0}.
- mem_we  out  1  1 = write.
- mem_wdata  out  64  store data shifted to its byte lane.
- mem_wstrb  out  8  byte enables; 0 for loads.
- mem_rsp_valid  in  1  read data ready / write acknowledged.
- mem_rdata  in  64  full doubleword read data.

Behaviour:
- Reset (sync, active-high): state=IDLE; every output 0; latched operation cleared.
- Reset mid-operation: return to IDLE next edge; mem_req_valid drops; no done pulse.
- IDLE:
  - If memread|memwrite, latch addr, rs2, funct3 and op. Stores take priority.
  - Illegal funct3: load 111, or store with funct3[2]=1. Go to DONE with fault_illegal.
  - Misaligned: H needs addr[0]=0, W needs addr[1:0]=0, D needs addr[2:0]=0. Go to DONE with fault_misaligned.
  - No memory request is issued for either fault.
  - Otherwise go to REQ.
- REQ:
  - mem_req_valid=1; mem_addr, mem_we, mem_wdata and mem_wstrb come from latched values and stay stable until accepted.
  - Store data: mem_wdata = rs2 << (8*addr[2:0]). Strobe is 1/3/F/FF shifted by addr[2:0] for B/H/W/D.
  - When mem_req_valid && mem_req_ready, go to WAIT_RSP.
- WAIT_RSP:
  - mem_req_valid=0.
  - On mem_rsp_valid: for loads, shift mem_rdata right by 8*addr[2:0], then sign-extend (LB/LH/LW/LD) or zero-extend (LBU/LHU/LWU) into load_data. Go to DONE.
- DONE:
  - done=1 for exactly one cycle; fault flags valid this cycle only; busy=1.
  - Next state is IDLE.
- Latency: with ready=1 on entry and response one cycle after accept, done arrives 3 cycles after memread/memwrite is sampled. Fault paths give done 1 cycle after sampling.
- Core contract: hold memread/memwrite and operands stable until done; a new op is sampled in the IDLE cycle after DONE.
- Robustness: mem_rsp_valid outside WAIT_RSP is ignored. The responder never asserts response in the accept cycle.
- load_data is unchanged by stores and by faulted operations.

Optional Feature:
- Macro LSU_TIMEOUT_EN.
- Defined:
  - An 8+ bit counter clears on entry to REQ and counts every cycle in REQ/WAIT_RSP.
  - On reaching TIMEOUT_CYCLES, drop mem_req_valid and go to DONE with fault_timeout=1.
  - A late response afterwards is ignored.
- Undefined: no counter; the unit waits indefinitely; fault_timeout is tied 0.

Decomposition:
- Package lsu_pkg holds:
  - state enum IDLE/REQ/WAIT_RSP/DONE;
  - funct3 constants F3_B/H/W/D/BU/HU/WU;
  - size-to-strobe table.
- Sub-module lsu_load_align: purely combinational (mem_rdata, offset, funct3 -> extended data), reused by a future pipelined LSU.

Test Plan:
- LD addr 0x10, mem returns 0x0000000000000006, ready=1, rsp one cycle later: done on cycle 3, load_data=6, no faults.
- LB addr 0x0B, rdata 0x0000_0000_8000_0000: byte 3 = 0x80, load_data=0xFFFFFFFFFFFFFF80. Same with LBU: 0x80.
- SH addr 0x06, rs2=0x1234: mem_wstrb=0xC0, mem_wdata=0x1234_0000_0000_0000, mem_we=1. Hold ready=0 for 4 cycles; request outputs stable throughout.
- LW addr 0x02: done after 1 cycle with fault_misaligned=1, mem_req_valid never asserted. Load funct3=111: fault_illegal=1.
- Assert reset during WAIT_RSP, then pulse mem_rsp_valid: state IDLE, no done, load_data=0.
- With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=8, ready held 0: done with fault_timeout=1 exactly 8 cycles after entering REQ.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM states, RV64 funct3
// codes, size-to-strobe table and operand legality checks.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2,
    DONE     = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  // Byte-enable pattern for an access at offset 0; funct3[1:0] encodes size.
  function automatic logic [7:0] size_strb(input logic [1:0] sz);
    logic [7:0] s;
    case (sz)
      2'd0:    s = 8'h01;
      2'd1:    s = 8'h03;
      2'd2:    s = 8'h0F;
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

  function automatic logic f3_illegal(input logic is_store, input logic [2:0] f3);
    return is_store ? f3[2] : (f3 == 3'b111);
  endfunction

  function automatic logic misaligned(input logic [1:0] sz, input logic [2:0] off);
    logic m;
    case (sz)
      2'd1:    m = off[0];
      2'd2:    m = |off[1:0];
      2'd3:    m = |off;
      default: m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load data path: selects the addressed bytes of a doubleword
// and sign/zero-extends them according to funct3.
module lsu_load_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [2:0]      offset,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data
);

  logic [XLEN-1:0] sh;

  always_comb begin
    sh   = rdata >> {offset, 3'b000};
    data = sh;
    case (funct3)
      F3_B:    data = {{(XLEN-8){sh[7]}}, sh[7:0]};
      F3_H:    data = {{(XLEN-16){sh[15]}}, sh[15:0]};
      F3_W:    data = {{(XLEN-32){sh[31]}}, sh[31:0]};
      F3_D:    data = sh;
      F3_BU:   data = {{(XLEN-8){1'b0}}, sh[7:0]};
      F3_HU:   data = {{(XLEN-16){1'b0}}, sh[15:0]};
      F3_WU:   data = {{(XLEN-32){1'b0}}, sh[31:0]};
      default: data = sh;
    endcase
  end

endmodule

// File: rtl/lsu_mem_initiator.sv
// Load/store unit memory initiator: one valid/ready request per core memory op,
// valid-only response, extended load data back to the core.
// Optional response watchdog enabled by defining LSU_TIMEOUT_EN.
module lsu_mem_initiator
  import lsu_pkg::*;
#(
  parameter int XLEN           = 64,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            memread,
  input  logic            memwrite,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] rs2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] load_data,
  output logic            fault_misaligned,
  output logic            fault_illegal,
  output logic            fault_timeout,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_addr,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_wdata,
  output logic [7:0]      mem_wstrb,
  input  logic            mem_rsp_valid,
  input  logic [XLEN-1:0] mem_rdata
);

  lsu_state_e      state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] load_data_q, load_data_d;
  logic [2:0]      f3_q, f3_d;
  logic            we_q, we_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            req_vld_q, req_vld_d;
  logic            mis_q, mis_d;
  logic            ill_q, ill_d;
  logic            expired;
  logic [XLEN-1:0] aligned;

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             to_q, to_d;
`else
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT_CYCLES == 0);
`endif

  lsu_load_align #(.XLEN(XLEN)) u_align (
    .rdata  (mem_rdata),
    .offset (addr_q[2:0]),
    .funct3 (f3_q),
    .data   (aligned)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    f3_d        = f3_q;
    we_d        = we_q;
    load_data_d = load_data_q;
    mis_d       = 1'b0;
    ill_d       = 1'b0;
    expired     = 1'b0;
`ifdef LSU_TIMEOUT_EN
    to_d  = 1'b0;
    cnt_d = cnt_q;
    if (state_q == REQ || state_q == WAIT_RSP) begin
      cnt_d   = cnt_q + 1'b1;
      expired = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    end
`endif
    case (state_q)
      IDLE: begin
        if (memread | memwrite) begin
          addr_d  = alu_result;
          wdata_d = rs2;
          f3_d    = funct3;
          we_d    = memwrite;
          if (f3_illegal(memwrite, funct3)) begin
            state_d = DONE;
            ill_d   = 1'b1;
          end else if (misaligned(funct3[1:0], alu_result[2:0])) begin
            state_d = DONE;
            mis_d   = 1'b1;
          end else begin
            state_d = REQ;
`ifdef LSU_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
        end
      end
      REQ: begin
        if (expired) begin
          state_d = DONE;
`ifdef LSU_TIMEOUT_EN
          to_d    = 1'b1;
`endif
        end else if (req_vld_q && mem_req_ready) begin
          state_d = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        if (expired) begin
          state_d = DONE;
`ifdef LSU_TIMEOUT_EN
          to_d    = 1'b1;
`endif
        end else if (mem_rsp_valid) begin
          state_d = DONE;
          if (!we_q) load_data_d = aligned;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Status outputs are registered off the next state so they line up with it.
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DONE);
    req_vld_d = (state_d == REQ);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      f3_q        <= '0;
      we_q        <= 1'b0;
      load_data_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      req_vld_q   <= 1'b0;
      mis_q       <= 1'b0;
      ill_q       <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      cnt_q       <= '0;
      to_q        <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      f3_q        <= f3_d;
      we_q        <= we_d;
      load_data_q <= load_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      req_vld_q   <= req_vld_d;
      mis_q       <= mis_d;
      ill_q       <= ill_d;
`ifdef LSU_TIMEOUT_EN
      cnt_q       <= cnt_d;
      to_q        <= to_d;
`endif
    end
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign load_data        = load_data_q;
  assign fault_misaligned = mis_q;
  assign fault_illegal    = ill_q;
`ifdef LSU_TIMEOUT_EN
  assign fault_timeout    = to_q;
`else
  assign fault_timeout    = 1'b0;
`endif

  // Request fields are only driven while the request is outstanding.
  assign mem_req_valid = req_vld_q;
  assign mem_addr      = req_vld_q ? {addr_q[XLEN-1:3], 3'b000} : '0;
  assign mem_we        = req_vld_q & we_q;
  assign mem_wdata     = req_vld_q ? (wdata_q << {addr_q[2:0], 3'b000}) : '0;
  assign mem_wstrb     = (req_vld_q & we_q) ? (size_strb(f3_q[1:0]) << addr_q[2:0]) : 8'h00;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Scoreboard bench for lsu_mem_initiator with a cycle-stepped responder model.
module tb_lsu_mem_initiator;
  import lsu_pkg::*;

`ifdef LSU_TIMEOUT_EN
  localparam int TO_CYC = 8;
`else
  localparam int TO_CYC = 255;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        memread, memwrite;
  logic [2:0]  funct3;
  logic [63:0] alu_result, rs2;
  logic        busy, done;
  logic [63:0] load_data;
  logic        fault_misaligned, fault_illegal, fault_timeout;
  logic        mem_req_valid, mem_req_ready;
  logic [63:0] mem_addr;
  logic        mem_we;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wstrb;
  logic        mem_rsp_valid;
  logic [63:0] mem_rdata;

  always #5 clk = ~clk;

  lsu_mem_initiator #(.XLEN(64), .TIMEOUT_CYCLES(TO_CYC)) dut (
    .clk(clk), .reset(reset), .memread(memread), .memwrite(memwrite),
    .funct3(funct3), .alu_result(alu_result), .rs2(rs2),
    .busy(busy), .done(done), .load_data(load_data),
    .fault_misaligned(fault_misaligned), .fault_illegal(fault_illegal),
    .fault_timeout(fault_timeout),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic [63:0] ld;
    logic        mis, ill, to, req;
    int          lat;
    logic [63:0] maddr, mwdata;
    logic        mwe;
    logic [7:0]  mwstrb;
  } exp_t;

  exp_t sbq[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [63:0] ld, input logic mis, ill, to, req,
                              input int lat, input logic [63:0] maddr, mwdata,
                              input logic mwe, input logic [7:0] mwstrb);
    exp_t e;
    e.ld = ld; e.mis = mis; e.ill = ill; e.to = to; e.req = req; e.lat = lat;
    e.maddr = maddr; e.mwdata = mwdata; e.mwe = mwe; e.mwstrb = mwstrb;
    return e;
  endfunction

  // Drive one op, act as responder (ready after rdy_wait REQ cycles, response
  // the cycle after accept), and score the completion against the queue head.
  task automatic run_op(input string tag, input logic st, input logic [2:0] f3,
                        input logic [63:0] addr, input logic [63:0] wd,
                        input logic [63:0] rd, input int rdy_wait, input exp_t e);
    int   cyc  = 0;
    int   rq   = 0;
    bit   acc  = 0;
    bit   seen = 0;
    bit   fin  = 0;
    exp_t x;
    exp_t hd;
    hd = e;
    sbq.push_back(e);
    @(negedge clk);
    memwrite = st; memread = !st; funct3 = f3; alu_result = addr; rs2 = wd;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
    while (!fin && cyc < 200) begin
      @(negedge clk);
      cyc++;
      mem_rsp_valid = 1'b0;
      mem_rdata     = '0;
      if (acc) begin
        mem_rsp_valid = 1'b1;
        mem_rdata     = rd;
        acc           = 0;
      end
      if (cyc == 1) chk({tag, "/busy"}, busy, 1);
      if (done) begin
        fin = 1;
        memread = 1'b0; memwrite = 1'b0; mem_req_ready = 1'b0;
        if (sbq.size() == 0) chk({tag, "/sb_empty"}, 0, 1);
        else begin
          x = sbq.pop_front();
          chk({tag, "/lat"},   cyc,              x.lat);
          chk({tag, "/ldata"}, load_data,        x.ld);
          chk({tag, "/mis"},   fault_misaligned, x.mis);
          chk({tag, "/ill"},   fault_illegal,    x.ill);
          chk({tag, "/to"},    fault_timeout,    x.to);
          chk({tag, "/req"},   seen,             x.req);
        end
      end else if (mem_req_valid) begin
        seen = 1;
        rq++;
        chk({tag, "/maddr"}, mem_addr,  hd.maddr);
        chk({tag, "/mwe"},   mem_we,    hd.mwe);
        chk({tag, "/wdata"}, mem_wdata, hd.mwdata);
        chk({tag, "/wstrb"}, mem_wstrb, hd.mwstrb);
        mem_req_ready = (rq > rdy_wait);
        acc = mem_req_ready;
      end else begin
        mem_req_ready = 1'b0;
      end
    end
    if (!fin) chk({tag, "/no_done"}, 0, 1);
  endtask

  initial begin
    int n;
    reset = 1'b1; memread = 1'b0; memwrite = 1'b0; funct3 = '0;
    alu_result = '0; rs2 = '0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0;
    repeat (3) @(negedge clk);
    chk("rst/busy",  busy, 0);
    chk("rst/done",  done, 0);
    chk("rst/ldata", load_data, 0);
    chk("rst/valid", mem_req_valid, 0);
    chk("rst/wstrb", mem_wstrb, 0);
    chk("rst/fault", {fault_misaligned, fault_illegal, fault_timeout}, 0);
    reset = 1'b0;

    run_op("ld",  0, F3_D,  64'h10, 0, 64'h6, 0,
           mk(64'h6, 0, 0, 0, 1, 3, 64'h10, 0, 0, 8'h00));
    run_op("lb",  0, F3_B,  64'h0B, 0, 64'h0000_0000_8000_0000, 0,
           mk(64'hFFFF_FFFF_FFFF_FF80, 0, 0, 0, 1, 3, 64'h08, 0, 0, 8'h00));
    run_op("lbu", 0, F3_BU, 64'h0B, 0, 64'h0000_0000_8000_0000, 0,
           mk(64'h80, 0, 0, 0, 1, 3, 64'h08, 0, 0, 8'h00));
    run_op("sh",  1, F3_H,  64'h06, 64'h1234, 0, 4,
           mk(64'h80, 0, 0, 0, 1, 7, 64'h00, 64'h1234_0000_0000_0000, 1, 8'hC0));
    run_op("lw_mis", 0, F3_W, 64'h02, 0, 0, 0,
           mk(64'h80, 1, 0, 0, 0, 1, 0, 0, 0, 8'h00));
    run_op("ld_ill", 0, 3'b111, 64'h10, 0, 0, 0,
           mk(64'h80, 0, 1, 0, 0, 1, 0, 0, 0, 8'h00));
    run_op("st_ill", 1, F3_BU, 64'h00, 64'h55, 0, 0,
           mk(64'h80, 0, 1, 0, 0, 1, 0, 0, 0, 8'h00));
    run_op("lh",  0, F3_H,  64'h0E, 0, 64'h8001_0000_0000_0000, 0,
           mk(64'hFFFF_FFFF_FFFF_8001, 0, 0, 0, 1, 3, 64'h08, 0, 0, 8'h00));
    run_op("lwu", 0, F3_WU, 64'h04, 0, 64'hDEAD_BEEF_0000_0000, 0,
           mk(64'h0000_0000_DEAD_BEEF, 0, 0, 0, 1, 3, 64'h00, 0, 0, 8'h00));
    run_op("lw",  0, F3_W,  64'h04, 0, 64'hDEAD_BEEF_0000_0000, 0,
           mk(64'hFFFF_FFFF_DEAD_BEEF, 0, 0, 0, 1, 3, 64'h00, 0, 0, 8'h00));
    run_op("sb",  1, F3_B,  64'h03, 64'hFFFF_FFFF_FFFF_FFAB, 0, 1,
           mk(64'hFFFF_FFFF_DEAD_BEEF, 0, 0, 0, 1, 4, 64'h00, 64'hFFFF_FFFF_AB00_0000, 1, 8'h08));
    run_op("sd_mis", 1, F3_D, 64'h0C, 64'h1, 0, 0,
           mk(64'hFFFF_FFFF_DEAD_BEEF, 1, 0, 0, 0, 1, 0, 0, 0, 8'h00));
    run_op("lh_mis", 0, F3_H, 64'h05, 0, 0, 0,
           mk(64'hFFFF_FFFF_DEAD_BEEF, 1, 0, 0, 0, 1, 0, 0, 0, 8'h00));
`ifdef LSU_TIMEOUT_EN
    run_op("tmo", 0, F3_D, 64'h18, 0, 64'h5555, 1000,
           mk(64'hFFFF_FFFF_DEAD_BEEF, 0, 0, 1, 1, 9, 64'h18, 0, 0, 8'h00));
`else
    run_op("stall", 0, F3_D, 64'h18, 0, 64'h5555, 20,
           mk(64'h5555, 0, 0, 0, 1, 23, 64'h18, 0, 0, 8'h00));
`endif

    // Reset while waiting for the response; the late response must be ignored.
    @(negedge clk);
    memread = 1'b1; funct3 = F3_D; alu_result = 64'h20; mem_req_ready = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mem_req_valid && n < 10);
    chk("mrst/req_seen", mem_req_valid, 1);
    mem_req_ready = 1'b1;
    @(negedge clk);
    chk("mrst/wait_busy", busy, 1);
    mem_req_ready = 1'b0; reset = 1'b1; memread = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    chk("mrst/busy",  busy, 0);
    chk("mrst/valid", mem_req_valid, 0);
    chk("mrst/ldata", load_data, 0);
    mem_rsp_valid = 1'b1; mem_rdata = 64'hABCD;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    chk("mrst/done",   done, 0);
    chk("mrst/busy2",  busy, 0);
    @(negedge clk);
    chk("mrst/done2",  done, 0);
    chk("mrst/ldata2", load_data, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
